// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues pipelined requests to a
// variable-latency in-order memory and buffers returned words for decode.
module fetch_queue #(
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [3:0]        HLT_OPCODE = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              deq_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              hlt
);

  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_W-1:0] q_inst_q [DEPTH];
  logic [DATA_W-1:0] q_inst_d [DEPTH];
  logic [ADDR_W-1:0] q_pc_q   [DEPTH];
  logic [ADDR_W-1:0] q_pc_d   [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [ADDR_W-1:0] pcf_q    [DEPTH];
  logic [ADDR_W-1:0] pcf_d    [DEPTH];
  logic [PW-1:0]     pcf_rd_q, pcf_rd_d;
  logic [PW-1:0]     pcf_wr_q, pcf_wr_d;
  logic              halted_q, halted_d;
  logic              hlt_q, hlt_d;

  logic              grant;
  logic              deq;
  logic              keep_rsp;
  logic [ADDR_W-1:0] rsp_pc;
  logic [CW:0]       credit_used;

  // Queued plus in-flight words never exceed DEPTH, so a response always has a slot.
  assign credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req    = !rst && !halted_q && !redirect && (credit_used < DEPTH_C);
  assign imem_addr   = fetch_pc_q;
  assign inst_valid  = (count_q != '0);
  assign inst        = q_inst_q[rd_ptr_q];
  assign inst_pc     = q_pc_q[rd_ptr_q];
  assign pc          = fetch_pc_q;
  assign hlt         = hlt_q;

  assign grant    = imem_req && imem_gnt;
  assign deq      = inst_valid && deq_ready && !redirect;
  assign rsp_pc   = pcf_q[pcf_rd_q];
  assign keep_rsp = imem_rvalid && !redirect && (drop_cnt_q == '0);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    q_inst_d      = q_inst_q;
    q_pc_d        = q_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    pcf_d         = pcf_q;
    pcf_rd_d      = pcf_rd_q;
    pcf_wr_d      = pcf_wr_q;
    halted_d      = halted_q;
    hlt_d         = hlt_q;

    // Issued-address FIFO tracks every response, including ones being dropped.
    if (grant) begin
      pcf_d[pcf_wr_q] = fetch_pc_q;
      pcf_wr_d        = pcf_wr_q + PW'(1);
      fetch_pc_d      = fetch_pc_q + ADDR_W'(2);
    end
    if (imem_rvalid) begin
      pcf_rd_d = pcf_rd_q + PW'(1);
    end

    unique case ({grant, imem_rvalid})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (redirect) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
      halted_d   = 1'b0;
      hlt_d      = 1'b0;
      drop_cnt_d = outstanding_q - CW'(imem_rvalid);
    end else begin
      if (imem_rvalid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (keep_rsp) begin
        q_inst_d[wr_ptr_q] = imem_rdata;
        q_pc_d[wr_ptr_q]   = rsp_pc;
        wr_ptr_d           = wr_ptr_q + PW'(1);
        if (imem_rdata[DATA_W-1 -: 4] == HLT_OPCODE) begin
          halted_d = 1'b1;
        end
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        if (inst[DATA_W-1 -: 4] == HLT_OPCODE) begin
          hlt_d = 1'b1;
        end
      end
      unique case ({keep_rsp, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      q_inst_q      <= '{default: '0};
      q_pc_q        <= '{default: '0};
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      pcf_q         <= '{default: '0};
      pcf_rd_q      <= '0;
      pcf_wr_q      <= '0;
      halted_q      <= 1'b0;
      hlt_q         <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      q_inst_q      <= q_inst_d;
      q_pc_q        <= q_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      pcf_q         <= pcf_d;
      pcf_rd_q      <= pcf_rd_d;
      pcf_wr_q      <= pcf_wr_d;
      halted_q      <= halted_d;
      hlt_q         <= hlt_d;
    end
  end

  // A response with nothing in flight means the memory broke the protocol.
  assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus randomized checks of fetch_queue against a queue-based model
// that tags in-flight fetches as stale on redirect.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] RPC   = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_gnt, imem_rvalid, redirect, deq_ready, inst_valid, hlt;
  logic [15:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc, pc;

  always #5 clk = ~clk;

  fetch_queue #(
    .DATA_W    (16),
    .ADDR_W    (16),
    .DEPTH     (DEPTH),
    .RESET_PC  (RPC),
    .HLT_OPCODE(4'hF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .deq_ready  (deq_ready),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .pc         (pc),
    .hlt        (hlt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory environment: in-order responses, each due a random latency after grant.
  typedef struct { logic [15:0] addr; int unsigned due; } rsp_t;
  rsp_t pend[$];
  int unsigned cyc = 0;
  int unsigned lat_min = 1, lat_max = 1, gnt_pct = 100, deq_pct = 100, rv_pct = 100;
  logic [15:0] halt_addr = 16'h0001;
  bit          rand_halt = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [3:0] op;
    if (a == halt_addr) return 16'hF000;
    if (rand_halt && a[5:1] == 5'h1F) return {4'hF, a[11:0]};
    op = a[4:1];
    if (op == 4'hF) op = 4'h7;
    return {op, a[11:0]};
  endfunction

  // Reference model
  typedef struct { logic [15:0] inst; logic [15:0] pc; } ent_t;
  typedef struct { logic [15:0] addr; bit stale; } fl_t;
  ent_t        mq[$];
  fl_t         mfl[$];
  logic [15:0] m_pc;
  bit          m_halted, m_hlt;

  logic        o_req, o_valid, o_hlt;
  logic [15:0] o_addr, o_inst_pc, o_inst, o_pc;

  task automatic model_reset();
    mq.delete();
    mfl.delete();
    pend.delete();
    m_pc     = RPC;
    m_halted = 1'b0;
    m_hlt    = 1'b0;
  endtask

  task automatic check_outputs(input bit m_req);
    chk("imem_req", imem_req, m_req);
    if (m_req) chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", inst_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("inst", inst, mq[0].inst);
      chk("inst_pc", inst_pc, mq[0].pc);
    end
    chk("pc", pc, m_pc);
    chk("hlt", hlt, m_hlt);
  endtask

  task automatic cycle(input bit do_redir, input logic [15:0] rpc);
    bit   m_req, hs, rv, deq;
    fl_t  f;
    @(negedge clk);
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    rv          = (pend.size() != 0) && (pend[0].due <= cyc) && ($urandom_range(99) < rv_pct);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(pend[0].addr) : 16'($urandom);
    redirect    = do_redir;
    redirect_pc = rpc;
    deq_ready   = ($urandom_range(99) < deq_pct);
    #1;
    m_req = !m_halted && !do_redir && (mq.size() + mfl.size() < DEPTH);
    check_outputs(m_req);
    o_req = imem_req; o_addr = imem_addr; o_valid = inst_valid;
    o_inst_pc = inst_pc; o_inst = inst; o_pc = pc; o_hlt = hlt;
    hs = m_req && imem_gnt;
    @(posedge clk);
    cyc++;
    if (rv) void'(pend.pop_front());
    if (hs) pend.push_back('{addr: m_pc, due: cyc - 1 + $urandom_range(lat_max, lat_min)});
    if (do_redir) begin
      mq.delete();
      m_pc = rpc; m_halted = 1'b0; m_hlt = 1'b0;
      if (rv) void'(mfl.pop_front());
      foreach (mfl[i]) mfl[i].stale = 1'b1;
    end else begin
      deq = (mq.size() != 0) && deq_ready;
      if (deq) begin
        if (mq[0].inst[15:12] == 4'hF) m_hlt = 1'b1;
        void'(mq.pop_front());
      end
      if (rv) begin
        f = mfl.pop_front();
        if (!f.stale) begin
          mq.push_back('{inst: imem_rdata, pc: f.addr});
          if (imem_rdata[15:12] == 4'hF) m_halted = 1'b1;
        end
      end
      if (hs) begin
        mfl.push_back('{addr: m_pc, stale: 1'b0});
        m_pc = m_pc + 16'd2;
      end
    end
  endtask

  task automatic do_reset(input int unsigned n);
    @(negedge clk);
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; deq_ready = 1'b0;
    #1;
    model_reset();
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_pc", pc, RPC);
    chk("rst_req", imem_req, 0);
    chk("rst_hlt", hlt, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int          grants, hdeq, hfirst;
    bit          first_seen;
    logic [15:0] first_pc;
    bit          r;
    logic [15:0] rp;

    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; deq_ready = 1'b0;
    model_reset();
    do_reset(3);

    // Streaming with a 1-cycle memory
    gnt_pct = 100; lat_min = 1; lat_max = 1; deq_pct = 100; rv_pct = 100;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 16'h0);
      chk("a_addr", o_addr, 16'(2 * i));
      if (i >= 2) begin
        chk("a_valid", o_valid, 1);
        chk("a_inst_pc", o_inst_pc, 16'(2 * (i - 2)));
      end
    end
    repeat (8) cycle(1'b0, 16'h0);

    // Back-pressure: queue fills, requests stop, then resume at 0x8
    do_reset(2);
    deq_pct = 0; grants = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 16'h0);
      if (o_req && imem_gnt) grants++;
    end
    chk("b_grants", grants, 4);
    chk("b_req_stall", o_req, 0);
    chk("b_valid", o_valid, 1);
    chk("b_inst_pc", o_inst_pc, 0);
    deq_pct = 100;
    cycle(1'b0, 16'h0);
    cycle(1'b0, 16'h0);
    chk("b_resume_req", o_req, 1);
    chk("b_resume_addr", o_addr, 16'h0008);
    repeat (6) cycle(1'b0, 16'h0);

    // Redirect with three fetches in flight on a slow memory
    do_reset(2);
    lat_min = 4; lat_max = 4;
    repeat (3) cycle(1'b0, 16'h0);
    cycle(1'b1, 16'h0100);
    chk("c_redir_req", o_req, 0);
    cycle(1'b0, 16'h0);
    chk("c_new_req", o_req, 1);
    chk("c_new_addr", o_addr, 16'h0100);
    chk("c_empty", o_valid, 0);
    first_seen = 1'b0; first_pc = '0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 16'h0);
      if (o_valid && !first_seen) begin first_seen = 1'b1; first_pc = o_inst_pc; end
    end
    chk("c_first_seen", first_seen, 1);
    chk("c_first_pc", first_pc, 16'h0100);

    // Halt opcode at 0x0006
    do_reset(2);
    lat_min = 1; lat_max = 1; halt_addr = 16'h0006;
    hdeq = -10; hfirst = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 16'h0);
      if (o_valid && o_inst == 16'hF000 && deq_ready) hdeq = i;
      if (o_hlt && hfirst < 0) hfirst = i;
    end
    chk("d_req_halted", o_req, 0);
    chk("d_hlt", o_hlt, 1);
    chk("d_pc", o_pc, 16'h000A);
    chk("d_hlt_latency", hfirst, hdeq + 1);
    halt_addr = 16'h0001;
    cycle(1'b1, 16'h0020);
    cycle(1'b0, 16'h0);
    chk("d_hlt_clear", o_hlt, 0);
    chk("d_resume_req", o_req, 1);
    chk("d_resume_addr", o_addr, 16'h0020);
    repeat (6) cycle(1'b0, 16'h0);

    // Redirect coincident with a response, then with a full queue
    do_reset(2);
    lat_min = 2; lat_max = 2; deq_pct = 0;
    repeat (4) cycle(1'b0, 16'h0);
    cycle(1'b1, 16'h0040);
    cycle(1'b0, 16'h0);
    chk("e_flush_valid", o_valid, 0);
    chk("e_new_addr", o_addr, 16'h0040);
    deq_pct = 100; first_seen = 1'b0; first_pc = '0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 16'h0);
      if (o_valid && !first_seen) begin first_seen = 1'b1; first_pc = o_inst_pc; end
    end
    chk("e_first_seen", first_seen, 1);
    chk("e_first_pc", first_pc, 16'h0040);
    deq_pct = 0;
    repeat (10) cycle(1'b0, 16'h0);
    chk("e_full_valid", o_valid, 1);
    chk("e_full_req", o_req, 0);
    cycle(1'b1, 16'h0060);
    cycle(1'b0, 16'h0);
    chk("e_full_flush", o_valid, 0);
    chk("e_full_addr", o_addr, 16'h0060);

    // Address wrap, then reset in the middle of a stream
    lat_min = 1; lat_max = 1; deq_pct = 100;
    cycle(1'b1, 16'hFFFE);
    cycle(1'b0, 16'h0);
    chk("f_addr_fffe", o_addr, 16'hFFFE);
    cycle(1'b0, 16'h0);
    chk("f_wrap_addr", o_addr, 16'h0000);
    chk("f_wrap_pc", o_pc, 16'h0000);
    deq_pct = 0;
    repeat (4) cycle(1'b0, 16'h0);
    chk("f_pre_reset_valid", o_valid, 1);
    do_reset(2);

    // Randomized traffic
    gnt_pct = 70; rv_pct = 70; lat_min = 1; lat_max = 4; deq_pct = 60; rand_halt = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(2);
      r  = ($urandom_range(99) < 3);
      rp = 16'($urandom) & 16'hFFFE;
      cycle(r, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
